// File: rtl/md_stall_ctrl_pkg.sv
// Shared MIPS opcode/func constants and MD unit latencies for the multiply/divide issue logic.
// The MD unit and md_stall_ctrl both take their latency values from here.
package md_stall_ctrl_pkg;

  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;

  localparam int unsigned MD_MULT_LAT = 5;
  localparam int unsigned MD_DIV_LAT  = 10;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FROZEN = 2'd2;

  typedef struct packed {
    logic is_md;
    logic is_start;
    logic is_div;
  } md_class_t;

endpackage

// File: rtl/md_stall_ctrl_if.sv
// D/E instruction, MD handshake and stall-control bundle between the pipeline and md_stall_ctrl.
interface md_stall_ctrl_if #(
  parameter int unsigned CNT_W = 5
) ();

  logic [31:0]      instr_d;
  logic [31:0]      instr_e;
  logic             md_start;
  logic             md_busy;
  logic             irq;
  logic             stall_d;
  logic             bubble_e;
  logic             md_pending;
  logic [CNT_W-1:0] pred_cnt;
  logic             proto_err;
  logic [31:0]      stall_cnt;

  modport master (
    output instr_d, instr_e, md_start, md_busy, irq,
    input  stall_d, bubble_e, md_pending, pred_cnt, proto_err, stall_cnt
  );

  modport slave (
    input  instr_d, instr_e, md_start, md_busy, irq,
    output stall_d, bubble_e, md_pending, pred_cnt, proto_err, stall_cnt
  );

endinterface

// File: rtl/md_stall_ctrl_class.sv
// Combinational MD-instruction decoder: flags any HI/LO user, the four issuing ops, and divides.
module md_class
  import md_stall_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output md_class_t   cls
);

  logic unused_bits;
  assign unused_bits = ^instr[25:6];

  always_comb begin
    cls = '0;
    if (instr[31:26] == OP_R) begin
      case (instr[5:0])
        FN_MULT, FN_MULTU: begin
          cls.is_md    = 1'b1;
          cls.is_start = 1'b1;
        end
        FN_DIV, FN_DIVU: begin
          cls.is_md    = 1'b1;
          cls.is_start = 1'b1;
          cls.is_div   = 1'b1;
        end
        FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO: cls.is_md = 1'b1;
        default: cls = '0;
      endcase
    end
  end

endmodule

// File: rtl/md_stall_ctrl.sv
// Stalls D while a multiply/divide is in flight, using a local countdown mirror of the MD unit.
// Also checks the unit's start/busy handshake against the mirror and counts stall cycles.
module md_stall_ctrl
  import md_stall_ctrl_pkg::*;
#(
  parameter int unsigned MULT_LAT = MD_MULT_LAT,
  parameter int unsigned DIV_LAT  = MD_DIV_LAT,
  parameter int unsigned CNT_W    = 5
) (
  input  logic           clk,
  input  logic           reset,
  md_stall_ctrl_if.slave md
);

  md_class_t        cls_d;
  md_class_t        cls_e;
  logic [1:0]       state_q;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] e_lat;
  logic             cnt_nz;
  logic             busy_exp;
  logic             stall;
  logic             proto_err_q;
  logic [31:0]      stall_cnt_q;
  logic             unused_cls;

  md_class u_class_d (.instr(md.instr_d), .cls(cls_d));
  md_class u_class_e (.instr(md.instr_e), .cls(cls_e));

  assign unused_cls = cls_d.is_start ^ cls_d.is_div ^ cls_e.is_md;

  assign e_lat    = cls_e.is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
  assign cnt_nz   = (cnt_q != '0);
  assign busy_exp = !cls_e.is_start && cnt_nz;
  assign stall    = cls_d.is_md && (cls_e.is_start || cnt_nz);

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cls_e.is_start && !md.irq) begin
          cnt_nxt   = e_lat;
          state_nxt = ST_RUN;
        end
      end
      // Leaving FROZEN counts down on the same edge, so irq adds exactly its own length.
      ST_RUN, ST_FROZEN: begin
        if (md.irq) begin
          state_nxt = ST_FROZEN;
        end else begin
          cnt_nxt   = cnt_q - CNT_W'(1);
          state_nxt = (cnt_q == CNT_W'(1)) ? ST_IDLE : ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      proto_err_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_nxt;
      cnt_q       <= cnt_nxt;
      proto_err_q <= proto_err_q || (md.md_busy != busy_exp) || (md.md_start != cls_e.is_start);
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign md.stall_d    = stall;
  assign md.bubble_e   = stall;
  assign md.md_pending = cnt_nz;
  assign md.pred_cnt   = cnt_q;
  assign md.proto_err  = proto_err_q;
  assign md.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_md_stall_ctrl.sv
// Self-checking bench for md_stall_ctrl: directed scenarios plus random instruction/irq traffic
// checked against a cycle-count reference model of the MD issue rules.
module tb_md_stall_ctrl;

  localparam logic [31:0] W_NOP   = 32'h0000_0000;
  localparam logic [31:0] W_ADDU  = {6'h00, 5'd8, 5'd9, 5'd10, 5'd0, 6'h21};
  localparam logic [31:0] W_MULT  = {6'h00, 5'd8, 5'd9, 5'd0,  5'd0, 6'h18};
  localparam logic [31:0] W_MULTU = {6'h00, 5'd8, 5'd9, 5'd0,  5'd0, 6'h19};
  localparam logic [31:0] W_DIV   = {6'h00, 5'd8, 5'd9, 5'd0,  5'd0, 6'h1a};
  localparam logic [31:0] W_DIVU  = {6'h00, 5'd8, 5'd9, 5'd0,  5'd0, 6'h1b};
  localparam logic [31:0] W_MFHI  = {6'h00, 5'd0, 5'd0, 5'd10, 5'd0, 6'h10};
  localparam logic [31:0] W_MTHI  = {6'h00, 5'd8, 5'd0, 5'd0,  5'd0, 6'h11};
  localparam logic [31:0] W_MFLO  = {6'h00, 5'd0, 5'd0, 5'd10, 5'd0, 6'h12};
  localparam logic [31:0] W_MTLO  = {6'h00, 5'd8, 5'd0, 5'd0,  5'd0, 6'h13};
  localparam logic [31:0] W_LWX   = {6'h23, 20'h12345, 6'h18};

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  int          rem;
  bit          m_perr;
  logic [31:0] m_scnt;
  logic [31:0] words [11];

  md_stall_ctrl_if #(.CNT_W(5)) bus ();

  md_stall_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_md(input logic [31:0] w);
    if (w[31:26] != 6'h00) return 1'b0;
    return (w[5:0] inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b});
  endfunction

  function automatic bit is_start(input logic [31:0] w);
    if (w[31:26] != 6'h00) return 1'b0;
    return (w[5:0] inside {6'h18, 6'h19, 6'h1a, 6'h1b});
  endfunction

  function automatic int lat(input logic [31:0] w);
    return (w[5:0] inside {6'h1a, 6'h1b}) ? 10 : 5;
  endfunction

  // One clock: drive at negedge, check outputs, then advance the model to the coming edge.
  task automatic cycle(input logic [31:0] d, input logic [31:0] e, input bit irq_v,
                       input bit bad_start, input bit bad_busy);
    bit es;
    bit ideal_busy;
    bit st;
    bit bs;
    bit exp_stall;
    @(negedge clk);
    es         = is_start(e);
    ideal_busy = !es && (rem > 0);
    st         = es ^ bad_start;
    bs         = ideal_busy ^ bad_busy;
    bus.instr_d  = d;
    bus.instr_e  = e;
    bus.irq      = irq_v;
    bus.md_start = st;
    bus.md_busy  = bs;
    #1;
    exp_stall = is_md(d) && (es || rem > 0);
    check("stall_d",    32'(bus.stall_d),    32'(exp_stall));
    check("bubble_e",   32'(bus.bubble_e),   32'(exp_stall));
    check("md_pending", 32'(bus.md_pending), 32'(rem > 0));
    check("pred_cnt",   32'(bus.pred_cnt),   32'(rem));
    check("proto_err",  32'(bus.proto_err),  32'(m_perr));
    check("stall_cnt",  bus.stall_cnt,       m_scnt);
    if ((st != es) || (bs != ideal_busy)) m_perr = 1'b1;
    if (exp_stall && (m_scnt != 32'hFFFF_FFFF)) m_scnt = m_scnt + 32'd1;
    if (rem == 0) begin
      if (es && !irq_v) rem = lat(e);
    end else if (!irq_v) begin
      rem = rem - 1;
    end
  endtask

  task automatic do_reset();
    #1;
    reset        = 1'b0;
    bus.instr_d  = W_MFLO;
    bus.instr_e  = W_NOP;
    bus.irq      = 1'b0;
    bus.md_start = 1'b0;
    bus.md_busy  = 1'b0;
    rem    = 0;
    m_perr = 1'b0;
    m_scnt = '0;
    #1;
    check("rst_pred_cnt",  32'(bus.pred_cnt),  32'd0);
    check("rst_stall_cnt", bus.stall_cnt,      32'd0);
    check("rst_proto_err", 32'(bus.proto_err), 32'd0);
    check("rst_stall_d",   32'(bus.stall_d),   32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] base;
    checks   = 0;
    failures = 0;
    words = '{W_NOP, W_ADDU, W_MULT, W_MULTU, W_DIV, W_DIVU, W_MFHI, W_MTHI, W_MFLO, W_MTLO, W_LWX};
    reset = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    base = m_scnt;
    cycle(W_MFHI, W_MULT, 0, 0, 0);
    repeat (6) cycle(W_MFHI, W_NOP, 0, 0, 0);
    check("mult_mfhi_stalls", bus.stall_cnt - base, 32'd6);

    base = m_scnt;
    cycle(W_ADDU, W_DIVU, 0, 0, 0);
    repeat (11) cycle(W_ADDU, W_NOP, 0, 0, 0);
    check("divu_addu_stalls", bus.stall_cnt - base, 32'd0);

    base = m_scnt;
    cycle(W_MFHI, W_MULT, 0, 0, 0);
    repeat (2) cycle(W_MFHI, W_NOP, 0, 0, 0);
    repeat (3) cycle(W_MFHI, W_NOP, 1, 0, 0);
    repeat (4) cycle(W_MFHI, W_NOP, 0, 0, 0);
    check("irq_freeze_stalls", bus.stall_cnt - base, 32'd9);

    cycle(W_MFLO, W_DIV, 1, 0, 0);
    repeat (2) cycle(W_MFLO, W_NOP, 0, 0, 0);

    cycle(W_NOP, W_NOP, 0, 0, 1);
    repeat (4) cycle(W_ADDU, W_NOP, 0, 0, 0);
    check("proto_err_sticky", 32'(bus.proto_err), 32'd1);
    do_reset();

    cycle(W_NOP, W_MULT, 0, 0, 0);
    repeat (2) cycle(W_MFLO, W_NOP, 0, 0, 0);
    do_reset();
    repeat (2) cycle(W_MFLO, W_NOP, 0, 0, 0);

    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    m_scnt = 32'hFFFF_FFFE;
    cycle(W_MFHI, W_MULT, 0, 0, 0);
    repeat (7) cycle(W_MFHI, W_NOP, 0, 0, 0);
    check("stall_cnt_sat", bus.stall_cnt, 32'hFFFF_FFFF);
    do_reset();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(249) == 0) do_reset();
      cycle(words[$urandom_range(10)],
            ($urandom_range(2) == 0) ? words[$urandom_range(10)] : W_NOP,
            ($urandom_range(7) == 0),
            ($urandom_range(150) == 0),
            ($urandom_range(150) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
